// File: rtl/invkeyexpansion.sv
// ============================================================================
//  Module      : invkeyexpansion
//  Description : AES-128 round-key generator for the inverse cipher. Runs the
//                forward key schedule to round 10, then hands out round keys
//                10 down to 0 over a valid/ready interface.
//                Optional build macro INVKEY_CACHE_EN: remembers the last key
//                and its round-10 key so a repeated key skips the forward walk.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Byte rotation of a key-schedule word: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
module rotword (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  assign o_word = {i_word[23:0], i_word[31:24]};
endmodule

// Four parallel AES S-box lookups on one word.
module subword (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  // S-box table, entry 0x00 in the most significant byte.
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      // ~byte == 255-byte, which maps the index onto the MSB-first table.
      assign o_word[gi*8 +: 8] = c_sbox[{~i_word[gi*8 +: 8], 3'b000} +: 8];
    end
  endgenerate
endmodule

module invkeyexpansion #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  output logic         ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2
  } state_t;

  localparam logic [3:0] c_last = 4'(NR);
  localparam logic [7:0] c_rcon_last = 8'h36;

  state_t       r_state, w_state_nxt;
  logic [127:0] r_block, w_block_nxt;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic [7:0]   r_rcon, w_rcon_nxt;

  logic [31:0]  w_a, w_b, w_c, w_d, w_d_rev, w_rot_in, w_rot, w_sub, w_t;
  logic [31:0]  w_fa, w_fb, w_fc, w_fd;
  logic [127:0] w_fwd_block, w_rev_block;
  logic [7:0]   w_rcon_mul, w_rcon_div;
  logic [8:0]   w_rcon_div9;
  logic         w_hit;

  assign w_a = r_block[127:96];
  assign w_b = r_block[95:64];
  assign w_c = r_block[63:32];
  assign w_d = r_block[31:0];

  // The single SubWord unit is shared: forward uses d, reverse uses the
  // already-recovered previous d (d ^ c).
  assign w_d_rev  = w_d ^ w_c;
  assign w_rot_in = (r_state == ST_REV) ? w_d_rev : w_d;

  rotword u_rotword (.i_word(w_rot_in), .o_word(w_rot));
  subword u_subword (.i_word(w_rot),    .o_word(w_sub));

  assign w_t = w_sub ^ {r_rcon, 24'h0};

  assign w_fa = w_a ^ w_t;
  assign w_fb = w_b ^ w_fa;
  assign w_fc = w_c ^ w_fb;
  assign w_fd = w_d ^ w_fc;
  assign w_fwd_block = {w_fa, w_fb, w_fc, w_fd};
  assign w_rev_block = {w_a ^ w_t, w_b ^ w_a, w_c ^ w_b, w_d_rev};

  // rcon times x and divided by x in GF(2^8).
  assign w_rcon_mul  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  assign w_rcon_div9 = r_rcon[0] ? ({1'b0, r_rcon} ^ 9'h11b) : {1'b0, r_rcon};
  assign w_rcon_div  = w_rcon_div9[8:1];

`ifdef INVKEY_CACHE_EN
  logic [127:0] r_cache_key, r_cache_r10;
  logic         r_cache_valid;

  assign w_hit = r_cache_valid && (key == r_cache_key);

  // Cache: the key is captured on a missed start and marked usable only once
  // its round-10 key has been produced, so an aborted expansion never hits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cache_valid <= 1'b0;
      r_cache_key   <= '0;
      r_cache_r10   <= '0;
    end else if (r_state == ST_IDLE && start && !w_hit) begin
      r_cache_valid <= 1'b0;
      r_cache_key   <= key;
    end else if (r_state == ST_FWD && r_cnt == c_last - 4'd1) begin
      r_cache_valid <= 1'b1;
      r_cache_r10   <= w_fwd_block;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // State, block, counter and rcon registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_block <= '0;
      r_cnt   <= '0;
      r_rcon  <= 8'h01;
    end else begin
      r_state <= w_state_nxt;
      r_block <= w_block_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rcon  <= w_rcon_nxt;
    end
  end

  // Next-state logic for the forward walk and the handshaked reverse walk.
  always_comb begin
    w_state_nxt = r_state;
    w_block_nxt = r_block;
    w_cnt_nxt   = r_cnt;
    w_rcon_nxt  = r_rcon;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
`ifdef INVKEY_CACHE_EN
          if (w_hit) begin
            w_block_nxt = r_cache_r10;
            w_cnt_nxt   = c_last;
            w_rcon_nxt  = c_rcon_last;
            w_state_nxt = ST_REV;
          end else begin
            w_block_nxt = key;
            w_cnt_nxt   = 4'd0;
            w_rcon_nxt  = 8'h01;
            w_state_nxt = ST_FWD;
          end
`else
          w_block_nxt = key;
          w_cnt_nxt   = 4'd0;
          w_rcon_nxt  = 8'h01;
          w_state_nxt = ST_FWD;
`endif
        end
      end
      ST_FWD: begin
        w_block_nxt = w_fwd_block;
        w_cnt_nxt   = r_cnt + 4'd1;
        // rcon stays at its round-10 value so the reverse walk starts with it.
        if (r_cnt == c_last - 4'd1) begin
          w_state_nxt = ST_REV;
        end else begin
          w_rcon_nxt = w_rcon_mul;
        end
      end
      ST_REV: begin
        if (rk_ready) begin
          if (r_cnt == 4'd0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_block_nxt = w_rev_block;
            w_cnt_nxt   = r_cnt - 4'd1;
            w_rcon_nxt  = w_rcon_div;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ready    = (r_state == ST_IDLE) && !w_hit ? 1'b1 : (r_state == ST_IDLE);
  assign rk_valid = (r_state == ST_REV);
  assign rk       = r_block;
  assign rk_round = r_cnt;

endmodule

`default_nettype wire
